mult_div_unit: RTL
==================

# mult_div_unit

Sequential HI/LO multiply/divide unit instantiated inside the execute stage, alongside the ALU. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per cycle from the D/E pipeline register and runs multi-cycle operations against fixed latencies. It exposes `hi`/`lo` for MFHI/MFLO and a `busy` flag. The execute stage forwards `busy` to the decode-stage stall logic, so any HI/LO instruction in decode is held while an operation is in flight.

## Interface
- MULT_CYCLES, 5: cycles of busy following a MULT/MULTU start cycle.
- DIV_CYCLES, 10: cycles of busy following a DIV/DIVU start cycle.

- clk  input  1  clock
- reset  input  1  synchronous, active-high
- start  input  1  request valid this cycle; already qualified by the execute stage (0 for bubbles)
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight, or long operation starting this cycle
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- State: IDLE / RUN. Down-counter `cnt` of width sufficient for max(MULT_CYCLES, DIV_CYCLES). Result latches `res_hi`/`res_lo`.
- Accept condition: start && state==IDLE.
- **IDLE, accept, op 1-4**
  - Compute the result from `a`/`b` at the accepting edge and latch it into `res_hi`/`res_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN.
- **IDLE, accept, op 5/6**: write `a` into `hi`/`lo` at that edge. No busy.
- **op 0/7, or start=0**: no effect.
- **RUN**
  - Decrement `cnt` each edge.
  - On the edge where `cnt` goes 1→0: commit `res_hi`/`res_lo` into `hi`/`lo`; return to IDLE.
  - start during RUN is ignored (any op, including MTHI/MTLO). Decode stalls guarantee this never occurs legitimately.
- `busy` = (state==RUN) || (start && state==IDLE && op in 1..4). This is combinational, so the instruction immediately behind a MULT/DIV sees the stall in the same cycle the MULT/DIV is in execute.
- `hi`/`lo` are driven from registers only. Intermediate results are never visible.
- **Arithmetic**
  - MULT: 64-bit signed product; `hi`=[63:32], `lo`=[31:0].
  - MULTU: 64-bit unsigned product, same split.
  - DIV: `lo`=quotient truncated toward zero; `hi`=remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - DIVU: unsigned quotient and remainder.
  - b==0, DIV or DIVU: `hi`=a, `lo`=0xFFFFFFFF. Full latency still applies.
- Reset: `hi`=0, `lo`=0, `cnt`=0, state IDLE, `busy`=0 (given start=0). Reset during RUN aborts the operation. No commit occurs, and both registers become 0.

## Timing
- Cycle 0: accepted MULT. `busy`=1 combinationally.
- Cycles 1..MULT_CYCLES: `busy`=1.
- End of cycle MULT_CYCLES: `hi`/`lo` are written.
- Cycle MULT_CYCLES+1: new values visible and `busy`=0.
- DIV/DIVU: identical, using DIV_CYCLES.
- A new op may be accepted in cycle N+1, the first cycle with `busy`=0. Back-to-back long ops therefore have no gap beyond the latency.
- MTHI/MTLO accepted in cycle 0: value visible in cycle 1; `busy` stays 0.
- `busy` never depends on `a`/`b`. Its only combinational path is start/op → busy.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 → `busy` high cycles 0-5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → `busy` high cycles 0-10; cycle 11: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → after 10 cycles hi=0x00000007, lo=0xFFFFFFFF. DIVU 0xFFFFFFFF / 0x10 → lo=0x0FFFFFFF, hi=0xF.
- MULT 2×3 started, then MTLO a=0x1234 asserted in cycle 2 (during RUN) → ignored; final lo=6, hi=0. MTHI a=0xABCD from IDLE → hi=0xABCD next cycle, `busy` never asserted.
- DIV started; reset asserted in cycle 4 → cycle 5: hi=0, lo=0, `busy`=0; no later commit appears.
- Back-to-back: MULTU 5×5, then DIVU 100/7 accepted in cycle 6 → lo=25 in cycle 6; lo=14, hi=2 in cycle 17.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit for the execute stage.
// The result is computed and latched when the request is accepted. It is
// committed to HI/LO only after a fixed latency has elapsed, so HI/LO never
// show intermediate values. MTHI/MTLO write in a single cycle.
//
// state | meaning
// IDLE  | no operation in flight; may accept a request
// RUN   | long operation counting down; all requests ignored
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        res_hi_q, res_lo_q;
  logic [31:0]        hi_q, lo_q;

  logic [31:0]        res_hi_d, res_lo_d;
  logic               is_long;
  logic               is_mult;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a, mag_b, mag_b_safe, b_safe;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;

  assign is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);

  // busy depends only on state and start/op, never on the operands
  assign busy = (state_q == RUN) || (start && (state_q == IDLE) && is_long);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Products; both operands are extended to 64 bits so the multiply is full width
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division is done on magnitudes and the signs are restored afterwards.
  // The divisor is forced to 1 when zero so no divide-by-zero reaches the
  // arithmetic; the zero-divisor result is selected separately below.
  assign mag_a      = a[31] ? (32'd0 - a) : a;
  assign mag_b      = b[31] ? (32'd0 - b) : b;
  assign mag_b_safe = (b == 32'd0) ? 32'd1 : mag_b;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign quot_s     = mag_a / mag_b_safe;
  assign rem_s      = mag_a % mag_b_safe;
  assign quot_u     = a / b_safe;
  assign rem_u      = a % b_safe;

  // Select the result to latch when a long operation is accepted.
  // 0x80000000 / -1 falls out of the magnitude path as 0x80000000 rem 0.
  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (op)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          res_hi_d = a;
          res_lo_d = 32'hFFFF_FFFF;
        end else begin
          res_lo_d = (a[31] ^ b[31]) ? (32'd0 - quot_s) : quot_s;
          res_hi_d = a[31] ? (32'd0 - rem_s) : rem_s;
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res_hi_d = a;
          res_lo_d = 32'hFFFF_FFFF;
        end else begin
          res_lo_d = quot_u;
          res_hi_d = rem_u;
        end
      end
      default: begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
      end
    endcase
  end

  // Sequencer: accept in IDLE, count down in RUN, commit on the 1->0 step
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_long) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              cnt_q    <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_q  <= RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
